// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the shared iterative RV32M divider.
// Accepts DIV/DIVU/REM/REMU from EX, runs a restoring division on operand
// magnitudes (BITS_PER_CYCLE quotient bits per cycle), resolves divide-by-zero
// and signed overflow immediately, stalls the pipeline while busy, and
// presents registered quotient/remainder with a one-cycle done strobe.
module div_ctrl #(
    parameter int          WIDTH          = 32,
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [4:0]  ALU_DIV        = 5'h10,
    parameter logic [4:0]  ALU_DIVU       = 5'h11,
    parameter logic [4:0]  ALU_REM        = 5'h12,
    parameter logic [4:0]  ALU_REMU       = 5'h13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       ID_EX_alu_func,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divider_busy,
    output logic             done
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // State and datapath registers
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] dividend_q,  dividend_d;   // dividend magnitude, consumed MSB first
    logic [WIDTH-1:0] divisor_q,   divisor_d;    // divisor magnitude
    logic [WIDTH-1:0] prem_q,      prem_d;       // partial remainder
    logic [WIDTH-1:0] pquo_q,      pquo_d;       // partial quotient
    logic             quo_neg_q,   quo_neg_d;    // negate quotient on completion
    logic             rem_neg_q,   rem_neg_d;    // negate remainder on completion
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q,      done_d;

    // Op decode and accept qualification
    logic             is_div_op;
    logic             is_signed_op;
    logic             accept;
    logic             div_by_zero;
    logic             sgn_ovf;
    logic             opa_neg;
    logic             opb_neg;
    logic [WIDTH-1:0] opa_mag;
    logic [WIDTH-1:0] opb_mag;

    // Iteration datapath
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] step_dvd;
    logic [WIDTH:0]   shifted_v;
    logic [WIDTH:0]   diff_v;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Classify the presented ALU function
    always_comb begin
        is_div_op    = 1'b0;
        is_signed_op = 1'b0;
        case (ID_EX_alu_func)
            ALU_DIV, ALU_REM: begin
                is_div_op    = 1'b1;
                is_signed_op = 1'b1;
            end
            ALU_DIVU, ALU_REMU: begin
                is_div_op    = 1'b1;
            end
            default: begin
                is_div_op    = 1'b0;
                is_signed_op = 1'b0;
            end
        endcase
    end

    // A flush in the same cycle suppresses the accept entirely
    assign accept      = (state_q == IDLE) && start && is_div_op && !flush;
    assign div_by_zero = (opb == '0);
    assign sgn_ovf     = is_signed_op && (opa == MIN_NEG) && (opb == ALL_ONES);

    // Unsigned ops use the raw bit patterns as magnitudes
    assign opa_neg = is_signed_op && opa[WIDTH-1];
    assign opb_neg = is_signed_op && opb[WIDTH-1];
    assign opa_mag = opa_neg ? (~opa + 1'b1) : opa;
    assign opb_mag = opb_neg ? (~opb + 1'b1) : opb;

    // BITS_PER_CYCLE restoring steps chained combinationally within one cycle
    always_comb begin
        step_rem  = prem_q;
        step_quo  = pquo_q;
        step_dvd  = dividend_q;
        shifted_v = '0;
        diff_v    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            // Partial remainder is always below the divisor, so WIDTH+1 bits
            // hold the shifted value; diff_v[WIDTH] is the borrow.
            shifted_v = {step_rem, step_dvd[WIDTH-1]};
            diff_v    = shifted_v - {1'b0, divisor_q};
            step_rem  = diff_v[WIDTH] ? shifted_v[WIDTH-1:0] : diff_v[WIDTH-1:0];
            step_quo  = {step_quo[WIDTH-2:0], ~diff_v[WIDTH]};
            step_dvd  = {step_dvd[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the final iteration result
    assign quo_fix = quo_neg_q ? (~step_quo + 1'b1) : step_quo;
    assign rem_fix = rem_neg_q ? (~step_rem + 1'b1) : step_rem;

    // Next-state and next-output computation for the sequencing FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        prem_d      = prem_q;
        pquo_d      = pquo_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;

        if (flush) begin
            // Abort: no strobe, published results untouched
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (div_by_zero) begin
                            quotient_d  = ALL_ONES;
                            remainder_d = opa;
                            done_d      = 1'b1;
                            state_d     = DONE;
                        end else if (sgn_ovf) begin
                            quotient_d  = MIN_NEG;
                            remainder_d = '0;
                            done_d      = 1'b1;
                            state_d     = DONE;
                        end else begin
                            dividend_d  = opa_mag;
                            divisor_d   = opb_mag;
                            prem_d      = '0;
                            pquo_d      = '0;
                            cnt_d       = '0;
                            quo_neg_d   = opa_neg ^ opb_neg;
                            rem_neg_d   = opa_neg;
                            state_d     = CALC;
                        end
                    end
                end
                CALC: begin
                    dividend_d = step_dvd;
                    prem_d     = step_rem;
                    pquo_d     = step_quo;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        quotient_d  = quo_fix;
                        remainder_d = rem_fix;
                        done_d      = 1'b1;
                        cnt_d       = '0;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    // The finished op is still presented; do not re-accept it here
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Register update with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            pquo_q      <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            prem_q      <= prem_d;
            pquo_q      <= pquo_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    // Stall while accepting and while iterating; release in DONE
    assign divider_busy = accept || (state_q == CALC);
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;
    assign done         = done_q;

endmodule
